// File: rtl/xt_hb2_pkg.sv
// Shared types, widths and helpers for the xt_hb2 bus controller.
// Slave select strobes, master/slave bus records, channel state and the error read value.
package xt_hb2_pkg;

  localparam int HB_ADDR_WIDTH = 32;
  localparam int HB_ID_WIDTH   = 4;
  localparam logic [31:0] HB_ERR_RDATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic ren;
    logic wen;
  } sel_t;

  typedef struct packed {
    logic                     read;
    logic                     write;
    logic [HB_ADDR_WIDTH-1:0] raddr;
    logic [HB_ADDR_WIDTH-1:0] waddr;
    logic [31:0]              wdata;
    logic [1:0]               write_width;
  } hb_master_in_t;

  typedef struct packed {
    logic [HB_ADDR_WIDTH-1:0] raddr;
    logic [HB_ADDR_WIDTH-1:0] waddr;
    logic [31:0]              wdata;
    logic [1:0]               write_width;
  } hb_slave_t;

  typedef enum logic {
    HB_CH_IDLE,
    HB_CH_BUSY
  } hb_ch_state_e;

  // Device ID lives in the top address bits.
  function automatic logic [HB_ID_WIDTH-1:0] HB_GetID(input logic [HB_ADDR_WIDTH-1:0] addr);
    return addr[HB_ADDR_WIDTH-1 -: HB_ID_WIDTH];
  endfunction

endpackage

// File: rtl/xt_hb2_channel.sv
// One bus channel: registered round-robin arbiter, ownership FSM, ID decode and
// optional access timeout (present when XT_HB_TIMEOUT_EN is defined).
module xt_hb2_channel
  import xt_hb2_pkg::*;
#(
  parameter int MASTER_NUM = 2,
  parameter int DEVICE_NUM = 4,
  parameter logic [DEVICE_NUM-1:0][HB_ID_WIDTH-1:0] DEVICE_BASE_ID = '0,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int OWN_W = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [MASTER_NUM-1:0]                 req,
  input  logic [MASTER_NUM-1:0][HB_ID_WIDTH-1:0] id,
  input  logic [DEVICE_NUM-1:0]                 finish,
  output logic                                  busy,
  output logic [OWN_W-1:0]                      owner,
  output logic [MASTER_NUM-1:0]                 grant,
  output logic [DEVICE_NUM-1:0]                 sel,
  output logic [MASTER_NUM-1:0]                 done,
  output logic [MASTER_NUM-1:0]                 err
);

  hb_ch_state_e            state_q, state_d;
  logic [OWN_W-1:0]        owner_q, owner_d, ptr_q, ptr_d, pick, cand;
  logic [HB_ID_WIDTH-1:0]  own_id;
  logic [DEVICE_NUM-1:0]   hit;
  logic                    own_req, fin_hit, no_hit, tmo, fail, done_now, exit_now;

  assign busy    = (state_q == HB_CH_BUSY);
  assign owner   = owner_q;
  assign own_req = req[owner_q];
  assign own_id  = id[owner_q];

  // Scan ptr+1, ptr+2, ... so the last owner has lowest priority.
  always_comb begin
    pick = ptr_q;
    cand = '0;
    for (int i = MASTER_NUM; i >= 1; i--) begin
      cand = OWN_W'((int'(ptr_q) + i) % MASTER_NUM);
      if (req[cand]) pick = cand;
    end
  end

  for (genvar k = 0; k < DEVICE_NUM; k++) begin : g_dec
    if (k == DEVICE_NUM - 1) begin : g_last
      assign hit[k] = busy && (own_id >= DEVICE_BASE_ID[k]);
    end else begin : g_mid
      assign hit[k] = busy && (own_id >= DEVICE_BASE_ID[k]) && (own_id < DEVICE_BASE_ID[k+1]);
    end
  end

`ifdef XT_HB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (!busy) begin
      tmo_cnt_q <= '0;
    end else if (tmo_cnt_q != 16'hFFFF) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  assign tmo = busy && (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  // A finish in the same cycle as the timeout still counts as a normal completion.
  assign fin_hit  = |(finish & hit);
  assign no_hit   = ~|hit;
  assign fail     = busy && own_req && !fin_hit && (no_hit || tmo);
  assign done_now = busy && own_req && (fin_hit || fail);
  assign exit_now = busy && (!own_req || done_now);
  assign sel      = (busy && own_req && !fail) ? hit : '0;

  always_comb begin
    grant = '0;
    done  = '0;
    err   = '0;
    if (busy)     grant[owner_q] = 1'b1;
    if (done_now) done[owner_q]  = 1'b1;
    if (fail)     err[owner_q]   = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      HB_CH_IDLE: begin
        if (|req) begin
          state_d = HB_CH_BUSY;
          owner_d = pick;
        end
      end
      HB_CH_BUSY: begin
        if (exit_now) begin
          state_d = HB_CH_IDLE;
          ptr_d   = owner_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HB_CH_IDLE;
      owner_q <= '0;
      ptr_q   <= OWN_W'(MASTER_NUM - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: rtl/xt_hb2.sv
// Full-duplex HB bus controller: independent read and write channels, bus muxes,
// stall and read-data return. Define XT_HB_TIMEOUT_EN to enable access timeouts.
module xt_hb2
  import xt_hb2_pkg::*;
#(
  parameter int MASTER_NUM = 2,
  parameter int DEVICE_NUM = 4,
  parameter logic [DEVICE_NUM-1:0][HB_ID_WIDTH-1:0] DEVICE_BASE_ID = '0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  hb_master_in_t [MASTER_NUM-1:0]  master_in,
  input  logic [DEVICE_NUM-1:0][31:0]     device_data_in,
  input  logic [DEVICE_NUM-1:0]           read_finish,
  input  logic [DEVICE_NUM-1:0]           write_finish,
  output logic [31:0]                     hb_rdata,
  output hb_slave_t                       bus,
  output sel_t [DEVICE_NUM-1:0]           device_sel,
  output logic [MASTER_NUM-1:0]           read_grant,
  output logic [MASTER_NUM-1:0]           write_grant,
  output logic [MASTER_NUM-1:0]           stall_req,
  output logic [MASTER_NUM-1:0]           read_err,
  output logic [MASTER_NUM-1:0]           write_err
);

  localparam int OWN_W = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;

  logic [MASTER_NUM-1:0]                  rd_req, wr_req, rd_done, wr_done;
  logic [MASTER_NUM-1:0][HB_ID_WIDTH-1:0] rd_id, wr_id;
  logic [DEVICE_NUM-1:0]                  rd_sel, wr_sel;
  logic [OWN_W-1:0]                       rd_owner, wr_owner;
  logic                                   rd_busy, wr_busy;

  always_comb begin
    for (int i = 0; i < MASTER_NUM; i++) begin
      rd_req[i] = master_in[i].read;
      wr_req[i] = master_in[i].write;
      rd_id[i]  = HB_GetID(master_in[i].raddr);
      wr_id[i]  = HB_GetID(master_in[i].waddr);
    end
  end

  xt_hb2_channel #(
    .MASTER_NUM     (MASTER_NUM),
    .DEVICE_NUM     (DEVICE_NUM),
    .DEVICE_BASE_ID (DEVICE_BASE_ID),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rd_ch (
    .clk    (clk),
    .rst    (rst),
    .req    (rd_req),
    .id     (rd_id),
    .finish (read_finish),
    .busy   (rd_busy),
    .owner  (rd_owner),
    .grant  (read_grant),
    .sel    (rd_sel),
    .done   (rd_done),
    .err    (read_err)
  );

  xt_hb2_channel #(
    .MASTER_NUM     (MASTER_NUM),
    .DEVICE_NUM     (DEVICE_NUM),
    .DEVICE_BASE_ID (DEVICE_BASE_ID),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wr_ch (
    .clk    (clk),
    .rst    (rst),
    .req    (wr_req),
    .id     (wr_id),
    .finish (write_finish),
    .busy   (wr_busy),
    .owner  (wr_owner),
    .grant  (write_grant),
    .sel    (wr_sel),
    .done   (wr_done),
    .err    (write_err)
  );

  always_comb begin
    bus = '0;
    if (rd_busy) bus.raddr = master_in[rd_owner].raddr;
    if (wr_busy) begin
      bus.waddr       = master_in[wr_owner].waddr;
      bus.wdata       = master_in[wr_owner].wdata;
      bus.write_width = master_in[wr_owner].write_width;
    end
  end

  always_comb begin
    for (int k = 0; k < DEVICE_NUM; k++) begin
      device_sel[k].ren = rd_sel[k];
      device_sel[k].wen = wr_sel[k];
    end
  end

  // rd_sel is one-hot at most, so the OR-mux picks the decoded slave.
  always_comb begin
    hb_rdata = '0;
    if (|read_err) begin
      hb_rdata = HB_ERR_RDATA;
    end else begin
      for (int k = 0; k < DEVICE_NUM; k++) begin
        if (rd_sel[k]) hb_rdata = device_data_in[k];
      end
    end
  end

  assign stall_req = (rd_req & ~rd_done) | (wr_req & ~wr_done);

endmodule

// File: tb/tb_xt_hb2.sv
// Bench for xt_hb2: directed vectors with literal expectations plus a per-cycle
// transaction-level model of both channels.
module tb_xt_hb2;
  import xt_hb2_pkg::*;

  localparam int MN  = 2;
  localparam int DN  = 4;
  localparam int TMO = 4;
  localparam logic [DN-1:0][HB_ID_WIDTH-1:0] BASES = {4'd12, 4'd8, 4'd4, 4'd2};
`ifdef XT_HB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  hb_master_in_t [MN-1:0]  master_in;
  logic [DN-1:0][31:0]     device_data_in;
  logic [DN-1:0]           read_finish, write_finish;
  logic [31:0]             hb_rdata;
  hb_slave_t               bus;
  sel_t [DN-1:0]           device_sel;
  logic [MN-1:0]           read_grant, write_grant, stall_req, read_err, write_err;

  int n_checks = 0;
  int n_pass   = 0;
  int rlat[DN], wlat[DN], rcnt[DN], wcnt[DN];
  int lo_tab[DN+1] = '{2, 4, 8, 12, 16};

  xt_hb2 #(
    .MASTER_NUM     (MN),
    .DEVICE_NUM     (DN),
    .DEVICE_BASE_ID (BASES),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .master_in      (master_in),
    .device_data_in (device_data_in),
    .read_finish    (read_finish),
    .write_finish   (write_finish),
    .hb_rdata       (hb_rdata),
    .bus            (bus),
    .device_sel     (device_sel),
    .read_grant     (read_grant),
    .write_grant    (write_grant),
    .stall_req      (stall_req),
    .read_err       (read_err),
    .write_err      (write_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Slaves: finish after lat consecutive selected cycles (lat 0 = never).
  always @(posedge clk) begin
    for (int k = 0; k < DN; k++) begin
      rcnt[k] <= device_sel[k].ren ? rcnt[k] + 1 : 0;
      wcnt[k] <= device_sel[k].wen ? wcnt[k] + 1 : 0;
    end
  end

  always_comb begin
    for (int k = 0; k < DN; k++) begin
      read_finish[k]  = (rlat[k] != 0) && (rcnt[k] == rlat[k] - 1);
      write_finish[k] = (wlat[k] != 0) && (wcnt[k] == wlat[k] - 1);
    end
  end

  function automatic int dev_of(input logic [3:0] id);
    dev_of = -1;
    for (int k = 0; k < DN; k++)
      if (int'(id) >= lo_tab[k] && int'(id) <= lo_tab[k+1] - 1) dev_of = k;
  endfunction

  // Transaction-level model: per channel, who owns it, whose turn is next, how long it has run.
  bit m_busy[2];
  int m_own[2], m_ptr[2], m_age[2];

  always @(negedge clk) begin : model
    logic [MN-1:0] rq[2];
    logic [3:0]    idv[2][MN];
    logic [DN-1:0] fn[2];
    logic [MN-1:0] e_grant[2], e_err[2], e_done[2];
    logic [DN-1:0] e_sel[2];
    logic [31:0]   e_rdata;
    sel_t [DN-1:0] e_ds;
    logic [MN-1:0] e_stall;
    int o, d, cand;
    bit r, fin, er;

    for (int i = 0; i < MN; i++) begin
      rq[0][i]  = master_in[i].read;
      rq[1][i]  = master_in[i].write;
      idv[0][i] = master_in[i].raddr[31:28];
      idv[1][i] = master_in[i].waddr[31:28];
    end
    fn[0] = read_finish;
    fn[1] = write_finish;
    e_rdata = '0;

    for (int c = 0; c < 2; c++) begin
      e_grant[c] = '0; e_err[c] = '0; e_done[c] = '0; e_sel[c] = '0;
      if (rst) begin
        m_busy[c] = 1'b0; m_ptr[c] = MN - 1; m_own[c] = 0; m_age[c] = 0;
      end else if (m_busy[c]) begin
        o   = m_own[c];
        r   = rq[c][o];
        d   = dev_of(idv[c][o]);
        fin = (d >= 0) && fn[c][d];
        er  = r && !fin && (d < 0 || (TMO_EN && m_age[c] == TMO - 1));
        e_grant[c][o] = 1'b1;
        if (er) e_err[c][o] = 1'b1;
        if (r && (fin || er)) e_done[c][o] = 1'b1;
        if (r && d >= 0 && !er) e_sel[c][d] = 1'b1;
        if (c == 0) begin
          if (er) e_rdata = 32'hDEAD_BEEF;
          else if (r && d >= 0) e_rdata = device_data_in[d];
          chk("m_raddr", bus.raddr, master_in[o].raddr);
        end else begin
          chk("m_wbus", {bus.waddr, bus.wdata}, {master_in[o].waddr, master_in[o].wdata});
          chk("m_wwidth", bus.write_width, master_in[o].write_width);
        end
        if (!r || fin || er) begin
          m_busy[c] = 1'b0; m_ptr[c] = o;
        end else begin
          m_age[c]++;
        end
      end else if (|rq[c]) begin
        for (int s = MN; s >= 1; s--) begin
          cand = (m_ptr[c] + s) % MN;
          if (rq[c][cand]) m_own[c] = cand;
        end
        m_busy[c] = 1'b1; m_age[c] = 0;
      end
    end

    for (int k = 0; k < DN; k++) begin
      e_ds[k].ren = e_sel[0][k];
      e_ds[k].wen = e_sel[1][k];
    end
    e_stall = (rq[0] & ~e_done[0]) | (rq[1] & ~e_done[1]);

    chk("m_rgrant", read_grant, e_grant[0]);
    chk("m_wgrant", write_grant, e_grant[1]);
    chk("m_rerr", read_err, e_err[0]);
    chk("m_werr", write_err, e_err[1]);
    chk("m_sel", device_sel, e_ds);
    chk("m_stall", stall_req, e_stall);
    chk("m_rdata", hb_rdata, e_rdata);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] wseq[5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    int stall_cnt;
    master_in = '0;
    device_data_in[0] = 32'hA000_0000;
    device_data_in[1] = 32'h1234_5678;
    device_data_in[2] = 32'hA000_0002;
    device_data_in[3] = 32'hA000_0003;
    for (int k = 0; k < DN; k++) begin
      rlat[k] = 0; wlat[k] = 0; rcnt[k] = 0; wcnt[k] = 0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grants", {read_grant, write_grant}, 4'b0000);
    chk("rst_sel", device_sel, 8'h00);
    chk("rst_err", {read_err, write_err}, 4'b0000);
    cyc();
    rst = 1'b0;
    cyc();

    // Master 0 reads device 1 with a 3-cycle slave
    rlat[1] = 3;
    master_in[0].read  = 1'b1;
    master_in[0].raddr = 32'h4000_0010;
    cyc();
    @(negedge clk);
    chk("t1_grant", read_grant, 2'b01);
    chk("t1_stall", stall_req, 2'b01);
    cyc(); cyc();
    @(negedge clk);
    chk("t1_rdata", hb_rdata, 32'h1234_5678);
    chk("t1_stall_done", stall_req, 2'b00);
    chk("t1_err", read_err, 2'b00);
    cyc();
    master_in[0].read = 1'b0;
    @(negedge clk);
    chk("t1_grant_clr", read_grant, 2'b00);

    // Both masters write continuously, slaves finish at once
    cyc();
    wlat[2] = 1; wlat[3] = 1;
    master_in[0].write = 1'b1; master_in[0].waddr = 32'h8000_0000;
    master_in[0].wdata = 32'hAAAA_0000; master_in[0].write_width = 2'd2;
    master_in[1].write = 1'b1; master_in[1].waddr = 32'hC000_0004;
    master_in[1].wdata = 32'h5555_1111; master_in[1].write_width = 2'd1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("t2_wgrant%0d", i), write_grant, wseq[i]);
    end
    cyc();
    master_in[0].write = 1'b0; master_in[1].write = 1'b0;

    // Master 1 reads an unmapped ID
    cyc();
    master_in[1].read  = 1'b1;
    master_in[1].raddr = 32'h1000_0000;
    cyc();
    @(negedge clk);
    chk("t3_err", read_err, 2'b10);
    chk("t3_rdata", hb_rdata, 32'hDEAD_BEEF);
    chk("t3_sel", device_sel, 8'h00);
    chk("t3_stall", stall_req, 2'b00);
    cyc();
    master_in[1].read = 1'b0;

    // Slave 0 never finishes
    cyc();
    rlat[0] = 0;
    master_in[0].read  = 1'b1;
    master_in[0].raddr = 32'h2000_0000;
`ifdef XT_HB_TIMEOUT_EN
    rlat[1] = 1;
    master_in[1].read  = 1'b1;
    master_in[1].raddr = 32'h4000_0000;
    repeat (4) cyc();
    @(negedge clk);
    chk("t4_err", read_err, 2'b01);
    chk("t4_stall", stall_req, 2'b10);
    chk("t4_rdata", hb_rdata, 32'hDEAD_BEEF);
    cyc();
    master_in[0].read = 1'b0;
    @(negedge clk);
    chk("t4_idle", read_grant, 2'b00);
    cyc();
    @(negedge clk);
    chk("t4_next", read_grant, 2'b10);
    cyc();
    master_in[1].read = 1'b0;
`else
    stall_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      @(negedge clk);
      if (stall_req[0]) stall_cnt++;
    end
    chk("t4_stall_hold", stall_cnt, 100);
    chk("t4_noerr", read_err, 2'b00);
    cyc();
    master_in[0].read = 1'b0;
    @(negedge clk);
    chk("t4_abort_grant", read_grant, 2'b01);
    chk("t4_abort_err", read_err, 2'b00);
    cyc();
    @(negedge clk);
    chk("t4_idle", read_grant, 2'b00);
`endif

    // Concurrent read and write by different masters
    cyc();
    rlat[0] = 2; wlat[2] = 3;
    master_in[0].read  = 1'b1; master_in[0].raddr = 32'h2000_0000;
    master_in[1].write = 1'b1; master_in[1].waddr = 32'h8000_0040;
    master_in[1].wdata = 32'h3C3C_3C3C; master_in[1].write_width = 2'd0;
    cyc();
    @(negedge clk);
    chk("t5_rgrant", read_grant, 2'b01);
    chk("t5_wgrant", write_grant, 2'b10);
    cyc();
    @(negedge clk);
    chk("t5_rdata", hb_rdata, 32'hA000_0000);
    chk("t5_stall_mid", stall_req, 2'b10);
    cyc();
    master_in[0].read = 1'b0;
    @(negedge clk);
    chk("t5_stall_end", stall_req, 2'b00);
    chk("t5_wgrant_end", write_grant, 2'b10);
    cyc();
    master_in[1].write = 1'b0;

    // Reset mid-transaction
    cyc();
    rlat[0] = 0; rlat[1] = 0;
    master_in[0].read  = 1'b1; master_in[0].raddr = 32'h2000_0000;
    cyc(); cyc();
    #2 rst = 1'b1;
    #1;
    chk("t6_grant", {read_grant, write_grant}, 4'b0000);
    chk("t6_sel", device_sel, 8'h00);
    chk("t6_err", {read_err, write_err}, 4'b0000);
    master_in[1].read  = 1'b1; master_in[1].raddr = 32'h4000_0000;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    @(negedge clk);
    chk("t6_first", read_grant, 2'b01);
    cyc();
    master_in[0].read = 1'b0; master_in[1].read = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    chk("t6_drain", read_grant, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
